// File: rtl/tl_ul_channel_buffer.sv
// Registered TL-UL channel buffer: a DEPTH-entry FIFO on A (master->slave) and on D (slave->master),
// plus a limiter that holds back A once MAX_INFLIGHT requests are awaiting their D response.

// Handshake: a beat moves on the rising edge where valid & ready are both high; ready and valid are
// derived from registered occupancy only, and payload is stable while valid is held without ready.
module tl_ul_channel_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         enq_valid,
   output logic         enq_ready,
   input  logic [W-1:0] enq_data,
   output logic         deq_valid,
   input  logic         deq_fire,
   output logic [W-1:0] deq_data
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          enq_fire;

   assign enq_ready = (count != FULL);
   assign deq_valid = (count != '0);
   assign deq_data  = mem[rd_ptr];
   assign enq_fire  = enq_valid & enq_ready;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
         if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (enq_fire) mem[wr_ptr] <= enq_data;
   end
endmodule

module tl_ul_channel_buffer #(
   parameter int DEPTH        = 2,
   parameter int SRC_W        = 1,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             a_in_valid,
   output logic             a_in_ready,
   input  logic [2:0]       a_in_opcode,
   input  logic [2:0]       a_in_param,
   input  logic [1:0]       a_in_size,
   input  logic [SRC_W-1:0] a_in_source,
   input  logic [31:0]      a_in_address,
   input  logic [3:0]       a_in_mask,
   input  logic [31:0]      a_in_data,
   output logic             a_out_valid,
   input  logic             a_out_ready,
   output logic [2:0]       a_out_opcode,
   output logic [2:0]       a_out_param,
   output logic [1:0]       a_out_size,
   output logic [SRC_W-1:0] a_out_source,
   output logic [31:0]      a_out_address,
   output logic [3:0]       a_out_mask,
   output logic [31:0]      a_out_data,
   input  logic             d_in_valid,
   output logic             d_in_ready,
   input  logic [2:0]       d_in_opcode,
   input  logic [1:0]       d_in_param,
   input  logic [1:0]       d_in_size,
   input  logic [SRC_W-1:0] d_in_source,
   input  logic             d_in_denied,
   input  logic [31:0]      d_in_data,
   input  logic             d_in_corrupt,
   output logic             d_out_valid,
   input  logic             d_out_ready,
   output logic [2:0]       d_out_opcode,
   output logic [1:0]       d_out_param,
   output logic [1:0]       d_out_size,
   output logic [SRC_W-1:0] d_out_source,
   output logic             d_out_denied,
   output logic [31:0]      d_out_data,
   output logic             d_out_corrupt,
   output logic [7:0]       inflight
);
   localparam int AW = 76 + SRC_W;
   localparam int DW = 41 + SRC_W;
   localparam logic [7:0] INFL_MAX = 8'(MAX_INFLIGHT);

   logic [AW-1:0] a_head;
   logic          a_head_valid;
   logic          a_deq;
   logic [DW-1:0] d_head;
   logic          d_enq;
   logic          d_deq;
   logic [7:0]    inflight_q;

   tl_ul_channel_fifo #(.DEPTH(DEPTH), .W(AW)) u_a_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .enq_valid (a_in_valid),
      .enq_ready (a_in_ready),
      .enq_data  ({a_in_opcode, a_in_param, a_in_size, a_in_source,
                   a_in_address, a_in_mask, a_in_data}),
      .deq_valid (a_head_valid),
      .deq_fire  (a_deq),
      .deq_data  (a_head)
   );

   // The limiter only masks the A head; the FIFO keeps the beat until the slave can take it.
   assign a_out_valid = a_head_valid & (inflight_q != INFL_MAX);
   assign a_deq       = a_out_valid & a_out_ready;
   assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
           a_out_address, a_out_mask, a_out_data} = a_head;

   tl_ul_channel_fifo #(.DEPTH(DEPTH), .W(DW)) u_d_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .enq_valid (d_in_valid),
      .enq_ready (d_in_ready),
      .enq_data  ({d_in_opcode, d_in_param, d_in_size, d_in_source,
                   d_in_denied, d_in_data, d_in_corrupt}),
      .deq_valid (d_out_valid),
      .deq_fire  (d_deq),
      .deq_data  (d_head)
   );

   assign d_enq = d_in_valid & d_in_ready;
   assign d_deq = d_out_valid & d_out_ready;
   assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
           d_out_denied, d_out_data, d_out_corrupt} = d_head;

   // A response with nothing outstanding leaves the count at zero instead of wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q <= 8'd0;
      end else if (a_deq && !d_enq) begin
         inflight_q <= inflight_q + 8'd1;
      end else if (d_enq && !a_deq && (inflight_q != 8'd0)) begin
         inflight_q <= inflight_q - 8'd1;
      end
   end

   assign inflight = inflight_q;

   unsolicited_d_check : assert property (@(posedge clock) disable iff (!reset_n)
      !(d_enq && (inflight_q == 8'd0)))
      else $warning("tl_ul_channel_buffer: D response accepted with no outstanding A request");
endmodule
